// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, default widths, starve counter type.
package mips_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;
    localparam int CNT_W          = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [CNT_W-1:0] starve_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and shared-memory port signals around the arbiter.
interface mem_arbiter_if
    import mips_pkg::*;
    #(
        parameter int ADDR_W = DEF_ADDR_W,
        parameter int DATA_W = DEF_DATA_W
    ) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    logic              sel;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, sel
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, sel
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data ports with a saturating starve counter.
// Latency: combinational pick, counter updates on the grant edge.
// Backpressure: only advances while arb_en (arbiter idle); otherwise counter holds.
module mem_arb_pick
    import mips_pkg::*;
    #(
        parameter int STARVE_MAX = DEF_STARVE_MAX
    ) (
        input  logic clk,
        input  logic rst_n,
        input  logic arb_en,
        input  logic i_req,
        input  logic d_req,
        output logic grant,
        output logic grant_d
    );

    localparam starve_t SMAX = starve_t'(STARVE_MAX);

    starve_t starve_cnt;

    // Data normally wins; a fetch that has waited SMAX data grants takes the next slot.
    always_comb begin
        grant_d = d_req && !(i_req && (starve_cnt == SMAX));
        grant   = d_req || i_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (grant && !grant_d)
                starve_cnt <= '0;
            else if (grant_d && i_req)
                starve_cnt <= (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one registered shared-memory port, one transaction in flight.
// Latency: grant edge -> m_req; m_ready in first busy cycle gives ack one cycle later.
// Backpressure: m_* held until m_ready; requests ignored outside IDLE.
module mem_arbiter
    import mips_pkg::*;
    #(
        parameter int ADDR_W     = DEF_ADDR_W,
        parameter int DATA_W     = DEF_DATA_W,
        parameter int STARVE_MAX = DEF_STARVE_MAX
    ) (
        input logic          clk,
        input logic          rst_n,
        mem_arbiter_if.slave bus
    );

    logic [1:0]        state;
    logic              arb_en;
    logic              grant;
    logic              grant_d;
    logic [ADDR_W-1:0] addr_nxt;

    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              sel_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign arb_en   = (state == ST_IDLE);
    assign addr_nxt = grant_d ? bus.d_addr : bus.i_addr;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (arb_en),
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
        .grant   (grant),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            sel_q     <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        sel_q    <= grant_d;
                        m_addr_q <= addr_nxt;
                        m_we_q   <= grant_d & bus.d_we;
                        // Fetches never write, so the write-data register keeps its old value.
                        if (grant_d)
                            m_wdata_q <= bus.d_wdata;
                        m_req_q  <= 1'b1;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.m_ready) begin
                        m_req_q <= 1'b0;
                        if (!sel_q)
                            i_rdata_q <= bus.m_rdata;
                        else if (!m_we_q)
                            d_rdata_q <= bus.m_rdata;
                        i_ack_q <= !sel_q;
                        d_ack_q <= sel_q;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.sel     = sel_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: reactive requesters and memory, spec-level reference model.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // stimulus knobs
    int          i_rate, d_rate, we_mode, wfix, wmax;
    bit          spur, rfix_en;
    logic [31:0] rfix;

    // requester state
    bit i_pend, d_pend;

    // reference model: phase 0 = waiting for requests, 1 = memory access, 2 = ack cycle
    int          ph, starve, wcnt;
    bit          e_mreq, e_mwe, e_sel, e_iack, e_dack;
    logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;

    // observation
    int n_iack, n_dack, n_mreq_cyc;
    bit prev_mreq;
    bit grants[$];

    int n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; starve = 0; wcnt = 0;
        e_mreq = 0; e_mwe = 0; e_sel = 0; e_iack = 0; e_dack = 0;
        e_maddr = '0; e_mwdata = '0; e_irdata = '0; e_drdata = '0;
    endtask

    task automatic model_tick();
        bit wd, wi;
        case (ph)
            0: begin
                wd = bus.d_req && !(bus.i_req && starve == SMAX);
                wi = bus.i_req && !wd;
                if (wd) begin
                    starve   = bus.i_req ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
                    e_sel    = 1;
                    e_maddr  = bus.d_addr;
                    e_mwe    = bus.d_we;
                    e_mwdata = bus.d_wdata;
                end else if (wi) begin
                    starve  = 0;
                    e_sel   = 0;
                    e_maddr = bus.i_addr;
                    e_mwe   = 0;
                end else begin
                    starve = 0;
                end
                if (wd || wi) begin
                    e_mreq = 1;
                    ph     = 1;
                    wcnt   = (wfix >= 0) ? wfix : int'($urandom_range(0, wmax));
                end
            end
            1: begin
                if (bus.m_ready) begin
                    e_mreq = 0;
                    if (!e_sel)      e_irdata = bus.m_rdata;
                    else if (!e_mwe) e_drdata = bus.m_rdata;
                    e_iack = !e_sel;
                    e_dack = e_sel;
                    ph     = 2;
                end
            end
            default: begin
                e_iack = 0;
                e_dack = 0;
                ph     = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("m_req",    bus.m_req,   e_mreq);
        chk("m_we",     bus.m_we,    e_mwe);
        chk("m_addr",   bus.m_addr,  e_maddr);
        chk("m_wdata",  bus.m_wdata, e_mwdata);
        chk("sel",      bus.sel,     e_sel);
        chk("i_ack",    bus.i_ack,   e_iack);
        chk("d_ack",    bus.d_ack,   e_dack);
        chk("i_rdata",  bus.i_rdata, e_irdata);
        chk("d_rdata",  bus.d_rdata, e_drdata);
        chk("ack_excl", bus.i_ack & bus.d_ack, 0);
        if (bus.i_ack) n_iack++;
        if (bus.d_ack) n_dack++;
        if (bus.m_req) n_mreq_cyc++;
        if (bus.m_req && !prev_mreq) grants.push_back(bus.sel);
        prev_mreq = bus.m_req;
    endtask

    task automatic drive_next();
        if (i_pend && bus.i_ack) i_pend = 0;
        if (d_pend && bus.d_ack) d_pend = 0;
        if (!i_pend && $urandom_range(0, 99) < i_rate) begin
            i_pend     = 1;
            bus.i_addr = $urandom;
        end
        if (!d_pend && $urandom_range(0, 99) < d_rate) begin
            d_pend      = 1;
            bus.d_we    = (we_mode == 0) ? 1'($urandom_range(0, 1)) : (we_mode == 1);
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
        end
        bus.i_req = i_pend;
        bus.d_req = d_pend;
        if (ph == 1) begin
            bus.m_ready = (wcnt == 0);
            if (wcnt > 0) wcnt--;
        end else begin
            bus.m_ready = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        bus.m_rdata = rfix_en ? rfix : $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_tick();
        @(negedge clk);
        check_outputs();
        drive_next();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clr_stats();
        n_iack = 0; n_dack = 0; n_mreq_cyc = 0;
        grants.delete();
    endtask

    task automatic issue_i(input logic [31:0] addr);
        i_pend = 1; bus.i_addr = addr; bus.i_req = 1'b1;
    endtask

    task automatic issue_d(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        d_pend = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd; bus.d_req = 1'b1;
    endtask

    // called right after a negedge; asserts reset asynchronously and checks the immediate effect
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_req", bus.m_req, 0);
        chk("rst_i_ack", bus.i_ack, 0);
        chk("rst_d_ack", bus.d_ack, 0);
        chk("rst_sel",   bus.sel,   0);
        chk("rst_m_we",  bus.m_we,  0);
        model_reset();
        bus.m_ready = 1'b0;
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0; n_err = 0;
        i_rate = 0; d_rate = 0; we_mode = 0; wfix = 0; wmax = 4;
        spur = 0; rfix_en = 0; rfix = '0;
        i_pend = 0; d_pend = 0; prev_mreq = 0;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.m_ready = 0; bus.m_rdata = '0;
        model_reset();
        clr_stats();

        // reset state
        #12;
        chk("reset_m_req",   bus.m_req,   0);
        chk("reset_m_we",    bus.m_we,    0);
        chk("reset_m_addr",  bus.m_addr,  0);
        chk("reset_m_wdata", bus.m_wdata, 0);
        chk("reset_sel",     bus.sel,     0);
        chk("reset_i_ack",   bus.i_ack,   0);
        chk("reset_d_ack",   bus.d_ack,   0);
        chk("reset_i_rdata", bus.i_rdata, 0);
        chk("reset_d_rdata", bus.d_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // single fetch, zero-wait memory
        rfix_en = 1; rfix = 32'h8C08_0004; wfix = 0;
        clr_stats();
        issue_i(32'h0040_0000);
        run(5);
        chk("t1_iack_cnt", n_iack, 1);
        chk("t1_i_rdata",  bus.i_rdata, 32'h8C08_0004);
        chk("t1_grants",   grants.size(), 1);
        if (grants.size() > 0) chk("t1_owner", grants[0], 0);

        // load with known data, then a 3-wait store that must not touch d_rdata
        rfix = 32'h1234_5678;
        clr_stats();
        issue_d(1'b0, 32'h1001_0008, 32'h0);
        run(5);
        chk("t2_load_rdata", bus.d_rdata, 32'h1234_5678);
        rfix = 32'hA5A5_A5A5; wfix = 3;
        clr_stats();
        issue_d(1'b1, 32'h1001_0000, 32'hDEAD_BEEF);
        run(9);
        chk("t2_mreq_cycles", n_mreq_cyc, 4);
        chk("t2_dack_cnt",    n_dack, 1);
        chk("t2_d_rdata",     bus.d_rdata, 32'h1234_5678);
        chk("t2_owner",       grants.size() > 0 ? 32'(grants[0]) : 32'hFFFF_FFFF, 1);

        // both ports continuously requesting: D,D,D,D,I repeating
        wfix = 0; rfix_en = 0;
        run(3);
        clr_stats();
        i_rate = 100; d_rate = 100; we_mode = 0;
        for (int k = 0; k < 100 && grants.size() < 10; k++) step();
        chk("t3_grant_cnt", grants.size() >= 10, 1);
        for (int k = 0; k < 10 && k < grants.size(); k++)
            chk($sformatf("t3_order_%0d", k), grants[k], (k % 5 == 4) ? 0 : 1);
        i_rate = 0; d_rate = 0;
        run(12);

        // simultaneous single requests: data first, then fetch
        clr_stats();
        issue_i($urandom);
        issue_d(1'b0, $urandom, $urandom);
        run(10);
        chk("t4_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("t4_first",  grants[0], 1);
            chk("t4_second", grants[1], 0);
        end
        chk("t4_iack_cnt", n_iack, 1);
        chk("t4_dack_cnt", n_dack, 1);

        // reset during a long memory access
        wfix = 5;
        clr_stats();
        issue_d(1'b1, 32'h1001_0040, 32'hCAFE_F00D);
        run(3);
        chk("t5_busy", bus.m_req, 1);
        pulse_reset();
        wfix = 0;
        run(8);
        chk("t5_dack_cnt", n_dack, 1);
        chk("t5_grants",   grants.size(), 2);

        // random traffic with spurious m_ready and one mid-run reset
        wfix = -1; wmax = 4; spur = 1; we_mode = 0;
        i_rate = 35; d_rate = 45;
        run(1500);
        pulse_reset();
        run(1500);
        i_rate = 0; d_rate = 0;
        run(20);
        chk("t6_idle", bus.m_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
